// File: rtl/hud_pkg.sv
// Shared HUD definitions: word count, font word type and the VRAM writer state encoding.
// Also used by the HUD text generator and the text renderer.
package hud_pkg;

   // Seven 32-bit font words: score text, score digits, life markers.
   localparam int unsigned N_HUD_WORDS = 7;
   localparam int unsigned HUD_IDX_W   = $clog2(N_HUD_WORDS);

   // Four characters per word, byte0 is the leftmost character.
   typedef logic [31:0] font_word_t;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      WRITE,
      DONE
   } hud_wr_state_t;

   // Index of the final word of a sweep.
   function automatic logic [HUD_IDX_W-1:0] hud_last_idx();
      return HUD_IDX_W'(N_HUD_WORDS - 1);
   endfunction

endpackage

// File: rtl/hud_vram_writer_rise_detect.sv
// Registered rising-edge detector for frame-sync style level inputs.
module rise_detect (
   input  logic Clk,
   input  logic Reset,
   input  logic in_i,
   output logic rise_o
);

   logic in_q;

   // Delayed copy of the input level.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         in_q <= 1'b0;
      end else begin
         in_q <= in_i;
      end
   end

   assign rise_o = in_i & ~in_q;

endmodule

// File: rtl/hud_vram_writer.sv
// Copies the seven HUD font words into text-mode VRAM once per frame, on a vsync
// rise, and only when the HUD content changed since the last completed update.
// Writes always come from a snapshot taken in CAPTURE, so a sweep is never torn.
module hud_vram_writer
   import hud_pkg::*;
#(
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned ADDR_W    = 11
) (
   input  logic                                Clk,
   input  logic                                Reset,
   input  logic                                vsync,
   input  logic [N_HUD_WORDS-1:0][31:0]        reg_font_in,
   input  logic                                vram_gnt,
   output logic                                vram_req,
   output logic [ADDR_W-1:0]                   vram_addr,
   output logic [31:0]                         vram_wdata,
   output logic [3:0]                          vram_we,
   output logic                                busy,
   output logic                                update_done,
   output logic [7:0]                          update_count
);

   // The HUD block must not wrap around the top of the VRAM address space.
   if ((longint'(BASE_ADDR) + longint'(N_HUD_WORDS) - 1) >= (longint'(1) << ADDR_W)) begin : g_addr_chk
      $error("hud_vram_writer: BASE_ADDR + %0d does not fit in ADDR_W bits", N_HUD_WORDS - 1);
   end

   localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

   hud_wr_state_t                  state_q, state_d;
   logic [HUD_IDX_W-1:0]           idx_q, idx_d;
   logic [N_HUD_WORDS-1:0][31:0]   shadow_q, shadow_d;
   logic [N_HUD_WORDS-1:0][31:0]   last_q, last_d;
   logic                           force_q, force_d;
   logic [7:0]                     count_q, count_d;
   logic                           rise;

   rise_detect u_rise_detect (
      .Clk    (Clk),
      .Reset  (Reset),
      .in_i   (vsync),
      .rise_o (rise)
   );

   // State, snapshot and bookkeeping registers; force_q starts set so the first
   // frame after reset always paints the HUD.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         shadow_q <= '0;
         last_q   <= '0;
         force_q  <= 1'b1;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         last_q   <= last_d;
         force_q  <= force_d;
         count_q  <= count_d;
      end
   end

   // Next-state logic and Moore outputs of the update sweep.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      last_d      = last_q;
      force_d     = force_q;
      count_d     = count_q;
      vram_req    = 1'b0;
      vram_addr   = '0;
      vram_wdata  = '0;
      vram_we     = 4'h0;
      update_done = 1'b0;

      case (state_q)
         IDLE: begin
            // Rises seen in any other state are dropped on purpose.
            if (rise) begin
               state_d = CAPTURE;
            end
         end

         CAPTURE: begin
            shadow_d = reg_font_in;
            if (force_q || (reg_font_in != last_q)) begin
               idx_d   = '0;
               state_d = WRITE;
            end else begin
               state_d = IDLE;
            end
         end

         WRITE: begin
            vram_req   = 1'b1;
            vram_addr  = BaseAddr + ADDR_W'(idx_q);
            vram_wdata = shadow_q[idx_q];
            vram_we    = 4'hF;
            // Without a grant everything holds; the arbiter decides when we proceed.
            if (vram_gnt) begin
               if (idx_q == hud_last_idx()) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         DONE: begin
            last_d      = shadow_q;
            force_d     = 1'b0;
            update_done = 1'b1;
            count_d     = count_q + 8'd1;
            state_d     = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy         = (state_q != IDLE);
   assign update_count = count_q;

endmodule

// File: doc/hud_vram_writer.md
Name: hud_vram_writer

Overview:
Consumes the seven 32-bit HUD font words (score text, score digits, life markers) and copies them into the text-mode VRAM through a shared, arbitrated BRAM write port. It sits directly downstream of the HUD text generator and upstream of the VRAM/text renderer. Updates happen only at frame boundaries, on the rising edge of vsync, and only when the HUD content has changed, so the renderer never shows a half-written HUD.

Parameters:
BASE_ADDR, 0, VRAM word address of HUD word 0; word i goes to BASE_ADDR+i.
ADDR_W, 11, VRAM word-address width.

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
vsync  in  1  frame sync level from the VGA controller, already synchronous to Clk
reg_font_in  in  7x32  HUD font words [0..6], each 4 characters, byte0 leftmost
vram_gnt  in  1  arbiter grant; a write commits in any cycle with vram_req && vram_gnt
vram_req  out  1  write request
vram_addr  out  ADDR_W  word address
vram_wdata  out  32  write data
vram_we  out  4  byte enables: 4'hF while vram_req=1, else 4'h0
busy  out  1  high in any state other than IDLE
update_done  out  1  one-cycle pulse when a full 7-word update completes
update_count  out  8  number of completed updates; wraps 255 -> 0

Behaviour:
- Reset values: all outputs 0, state IDLE, vsync_d=0, force_write=1, shadow and last_written registers all 0.
- Edge detect: vsync_d is a registered copy of vsync; rise = vsync & ~vsync_d.
- States and transitions:
  - IDLE: on rise, go to CAPTURE; otherwise stay.
  - CAPTURE (1 cycle): shadow[i] <= reg_font_in[i] for all i. dirty = force_write, or any reg_font_in[i] != last_written[i]. If dirty, set idx <= 0 and go to WRITE; otherwise go to IDLE.
  - WRITE: vram_req=1, vram_addr=BASE_ADDR+idx, vram_wdata=shadow[idx], vram_we=4'hF.
    - On a commit cycle with idx<6: idx++.
    - On a commit cycle with idx==6: go to DONE.
    - With vram_gnt=0: addr, data and we hold unchanged, and there is no timeout.
  - DONE (1 cycle): last_written <= shadow, force_write <= 0, update_done=1, update_count++, go to IDLE.
- Latency, with full grant:
  - rise seen at edge k: CAPTURE at k+1.
  - First write request at k+2.
  - Last commit at k+8.
  - update_done pulse at k+9.
- All 7 words are always written once dirty; no per-word skipping.
- Snapshot consistency: data written comes only from shadow. Changes to reg_font_in after CAPTURE do not affect the current sweep; they are picked up at the next vsync rise.
- A vsync rise while busy (any state other than IDLE) is dropped, not queued. The next rise re-compares against last_written, so no change is ever lost.
- If vsync is held high, there is only one rise and therefore only one update.
- Reset mid-sweep:
  - Aborts immediately; vram_req drops on the next edge.
  - force_write=1, so the next rise rewrites all 7 words.
- No address wrap: BASE_ADDR+6 must fit in ADDR_W bits. An assertion checks this at elaboration.

Decomposition:
- Package hud_pkg:
  - N_HUD_WORDS=7
  - typedef logic [31:0] font_word_t
  - typedef enum {IDLE, CAPTURE, WRITE, DONE} hud_wr_state_t
  - shared with the HUD text generator and the text renderer.
- Sub-module: rise_detect (registered edge detector, Clk/Reset/in -> rise), reused for other frame-sync consumers.
- FSM, shadow, compare and idx logic stay in hud_vram_writer.

Test Plan:
- Reset, words = {72 6f 63 53, 00 00 7c 65, 30 35 00 00, 0, 45 46 49 4c, 00 00 00 7c, 00 00 83 83}, one vsync rise, vram_gnt=1 -> seven commits, addr 0..6 in consecutive cycles with matching data. update_done fires 9 cycles after the rise, update_count=1.
- Second vsync rise with identical inputs -> busy high for exactly 1 cycle (CAPTURE), no vram_req, update_count stays 1.
- Change word 2 to 32'h39300000, then vsync rise -> all 7 words rewritten, addr 2 data 39300000, update_count=2.
- vram_gnt low for 3 cycles while idx=4 -> addr 4, data, we=F held stable for 4 cycles, then the sweep completes. Total sweep latency grows by 3.
- Change reg_font_in during WRITE, plus an extra vsync rise mid-sweep -> the old snapshot is written intact and the extra rise is ignored. The following rise writes the new data.
- Assert Reset at idx=3, release it, change nothing, then vsync rise -> a full 7-word rewrite (force_write), update_count restarts from 0 to 1.
